// File: rtl/m68k_bus_bridge.sv
// m68k_bus_bridge
// Converts the asynchronous 68000 pin bus (AS/UDS/LDS/RW/DTACK/BERR) into the
// internal synchronous master bus (active-high uds/lds strobes, ack handshake,
// 32-bit address, 16-bit data). One request is outstanding at a time.
// Optional feature macro: BRIDGE_BERR_TIMEOUT_EN -- adds a timeout counter and
// a BERR state that terminates a request left unanswered for TIMEOUT_CYCLES.
module m68k_bus_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:1] cpu_addr,
    input  logic [15:0] cpu_data_in,
    output logic [15:0] cpu_data_out,
    output logic        cpu_data_oe,
    input  logic        cpu_as_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic        cpu_rw,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    output logic [31:0] master_addr,
    output logic [15:0] master_write,
    input  logic [15:0] master_read,
    output logic        master_uds,
    output logic        master_lds,
    output logic        master_rw,
    input  logic        master_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
`ifdef BRIDGE_BERR_TIMEOUT_EN
        ST_ACK  = 2'd2,
        ST_BERR = 2'd3
`else
        ST_ACK  = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic        as_m_q, as_s_q;
    logic        uds_m_q, uds_s_q;
    logic        lds_m_q, lds_s_q;
    logic [23:1] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        uds_q, uds_d;
    logic        lds_q, lds_d;
    logic        rw_q, rw_d;
    logic        dtack_n_q, dtack_n_d;
    logic        oe_q, oe_d;

`ifdef BRIDGE_BERR_TIMEOUT_EN
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        berr_n_q, berr_n_d;
`endif

    assign master_addr  = {8'h00, addr_q, 1'b0};
    assign master_write = wdata_q;
    assign master_uds   = uds_q;
    assign master_lds   = lds_q;
    assign master_rw    = rw_q;
    assign cpu_data_out = rdata_q;
    assign cpu_data_oe  = oe_q;
    assign cpu_dtack_n  = dtack_n_q;
`ifdef BRIDGE_BERR_TIMEOUT_EN
    assign cpu_berr_n   = berr_n_q;
`else
    assign cpu_berr_n   = 1'b1;
`endif

    // Two-flop synchronisers for the CPU strobes; they reset to the asserted
    // level so the bridge only arms once a genuine AS-high has propagated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            as_m_q  <= 1'b0;
            as_s_q  <= 1'b0;
            uds_m_q <= 1'b0;
            uds_s_q <= 1'b0;
            lds_m_q <= 1'b0;
            lds_s_q <= 1'b0;
        end else begin
            as_m_q  <= cpu_as_n;
            as_s_q  <= as_m_q;
            uds_m_q <= cpu_uds_n;
            uds_s_q <= uds_m_q;
            lds_m_q <= cpu_lds_n;
            lds_s_q <= lds_m_q;
        end
    end

    // State and registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            armed_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            uds_q     <= 1'b0;
            lds_q     <= 1'b0;
            rw_q      <= 1'b1;
            dtack_n_q <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            armed_q   <= armed_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            uds_q     <= uds_d;
            lds_q     <= lds_d;
            rw_q      <= rw_d;
            dtack_n_q <= dtack_n_d;
            oe_q      <= oe_d;
        end
    end

`ifdef BRIDGE_BERR_TIMEOUT_EN
    // Timeout counter and bus-error output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            berr_n_q <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            berr_n_q <= berr_n_d;
        end
    end
`endif

    // Next-state logic: latch the CPU cycle in IDLE, hold it in REQ until a
    // slave acks (or the timeout fires), then wait for AS to rise.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        uds_d     = uds_q;
        lds_d     = lds_q;
        rw_d      = rw_q;
        dtack_n_d = dtack_n_q;
        oe_d      = oe_q;
`ifdef BRIDGE_BERR_TIMEOUT_EN
        cnt_d     = cnt_q;
        berr_n_d  = berr_n_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (as_s_q) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !as_s_q && (!uds_s_q || !lds_s_q)) begin
                    addr_d  = cpu_addr;
                    rw_d    = cpu_rw;
                    wdata_d = cpu_data_in;
                    uds_d   = ~uds_s_q;
                    lds_d   = ~lds_s_q;
                    state_d = ST_REQ;
`ifdef BRIDGE_BERR_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_REQ: begin
                if (master_ack) begin
                    if (rw_q) begin
                        rdata_d = master_read;
                    end
                    uds_d     = 1'b0;
                    lds_d     = 1'b0;
                    dtack_n_d = 1'b0;
                    oe_d      = rw_q;
                    state_d   = ST_ACK;
                end
`ifdef BRIDGE_BERR_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    uds_d    = 1'b0;
                    lds_d    = 1'b0;
                    berr_n_d = 1'b0;
                    oe_d     = 1'b0;
                    state_d  = ST_BERR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_ACK: begin
                if (as_s_q) begin
                    dtack_n_d = 1'b1;
                    oe_d      = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
`ifdef BRIDGE_BERR_TIMEOUT_EN
            ST_BERR: begin
                if (as_s_q) begin
                    berr_n_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// tb_m68k_bus_bridge
// Self-checking bench for m68k_bus_bridge: a table of directed CPU cycles,
// randomized cycles checked against a transaction-level model, and hand
// sequences for timeout, back-to-back, early release and reset corner cases.
module tb_m68k_bus_bridge;

    localparam int unsigned TIMEOUT = 8;
`ifdef BRIDGE_BERR_TIMEOUT_EN
    localparam bit FEATURE = 1'b1;
`else
    localparam bit FEATURE = 1'b0;
`endif

    typedef struct {
        logic [23:0] byteAddr;
        logic        rw;
        logic        udsN;
        logic        ldsN;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ackDelay;
        logic [31:0] expAddr;
        logic        expUds;
        logic        expLds;
        logic        expOe;
        logic        expBerr;
        logic [15:0] expData;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [23:1] cpu_addr;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;
    logic        cpu_data_oe;
    logic        cpu_as_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_rw;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;
    logic [31:0] master_addr;
    logic [15:0] master_write;
    logic [15:0] master_read;
    logic        master_uds;
    logic        master_lds;
    logic        master_rw;
    logic        master_ack;

    int          assertCount = 0;
    int          failCount = 0;
    logic [15:0] lastRead;
    vec_t        vecs[5];

    m68k_bus_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_addr     (cpu_addr),
        .cpu_data_in  (cpu_data_in),
        .cpu_data_out (cpu_data_out),
        .cpu_data_oe  (cpu_data_oe),
        .cpu_as_n     (cpu_as_n),
        .cpu_uds_n    (cpu_uds_n),
        .cpu_lds_n    (cpu_lds_n),
        .cpu_rw       (cpu_rw),
        .cpu_dtack_n  (cpu_dtack_n),
        .cpu_berr_n   (cpu_berr_n),
        .master_addr  (master_addr),
        .master_write (master_write),
        .master_read  (master_read),
        .master_uds   (master_uds),
        .master_lds   (master_lds),
        .master_rw    (master_rw),
        .master_ack   (master_ack)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [23:0] byteAddr, input logic rw, input logic udsN,
                                 input logic ldsN, input logic [15:0] wdata);
        cpu_addr    = byteAddr[23:1];
        cpu_rw      = rw;
        cpu_data_in = wdata;
        cpu_uds_n   = udsN;
        cpu_lds_n   = ldsN;
        cpu_as_n    = 1'b0;
    endtask

    task automatic releaseCpu();
        cpu_as_n  = 1'b1;
        cpu_uds_n = 1'b1;
        cpu_lds_n = 1'b1;
    endtask

    task automatic waitStrobe(output int n);
        n = 0;
        while (!(master_uds || master_lds) && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic waitRelease(output int n);
        n = 0;
        while ((cpu_dtack_n !== 1'b1 || cpu_berr_n !== 1'b1 || cpu_data_oe !== 1'b0) && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "Dtack"}, 32'(cpu_dtack_n), 32'd1);
        checkOutput({tag, "Berr"},  32'(cpu_berr_n),  32'd1);
        checkOutput({tag, "Oe"},    32'(cpu_data_oe), 32'd0);
        checkOutput({tag, "Data"},  32'(cpu_data_out), 32'd0);
        checkOutput({tag, "Addr"},  master_addr, 32'd0);
        checkOutput({tag, "Write"}, 32'(master_write), 32'd0);
        checkOutput({tag, "Strb"},  32'({master_uds, master_lds}), 32'd0);
        checkOutput({tag, "Rw"},    32'(master_rw), 32'd1);
    endtask

    // One complete CPU cycle: strobe latency, latched request, slave
    // response (ack after ackDelay REQ cycles, or timeout), then release.
    task automatic runCycle(input vec_t v);
        int n;
        int noAck;
        logic sawDtack;
        master_read = v.rdata;
        applyStimulus(v.byteAddr, v.rw, v.udsN, v.ldsN, v.wdata);
        waitStrobe(n);
        checkOutput("strobeLatency", 32'(n), 32'd3);
        checkOutput("reqAddr", master_addr, v.expAddr);
        checkOutput("reqStrobes", 32'({master_uds, master_lds}), 32'({v.expUds, v.expLds}));
        checkOutput("reqRw", 32'(master_rw), 32'(v.rw));
        checkOutput("reqWrite", 32'(master_write), 32'(v.wdata));
        noAck = v.expBerr ? int'(TIMEOUT) : v.ackDelay;
        sawDtack = 1'b0;
        for (int i = 0; i < noAck; i++) begin
            tick();
            if (cpu_dtack_n == 1'b0) sawDtack = 1'b1;
        end
        if (!v.expBerr) begin
            checkOutput("strobeHold", 32'({master_uds, master_lds}), 32'({v.expUds, v.expLds}));
            master_ack = 1'b1;
            tick();
            master_ack = 1'b0;
        end
        checkOutput("dtackEarly", 32'(sawDtack), 32'd0);
        checkOutput("respDtack", 32'(cpu_dtack_n), 32'(v.expBerr));
        checkOutput("respBerr", 32'(cpu_berr_n), 32'(!v.expBerr));
        checkOutput("respOe", 32'(cpu_data_oe), 32'(v.expOe));
        checkOutput("respData", 32'(cpu_data_out), 32'(v.expData));
        checkOutput("respStrobesClear", 32'({master_uds, master_lds}), 32'd0);
        releaseCpu();
        waitRelease(n);
        checkOutput("releaseLatency", 32'(n), 32'd3);
        tick();
        tick();
    endtask

    initial begin
        int n;
        int rises;
        logic overlap;
        logic prevStrb;
        logic curStrb;
        vec_t v;
        logic [1:0] sel;

        // Directed table: byteAddr, rw, udsN, ldsN, wdata, rdata, ackDelay,
        // expAddr, expUds, expLds, expOe, expBerr, expData.
        vecs[0] = '{24'h000400, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 2,
                    32'h0000_0400, 1'b1, 1'b1, 1'b1, 1'b0, 16'hBEEF};
        vecs[1] = '{24'h100001, 1'b0, 1'b1, 1'b0, 16'h0055, 16'h1234, 1,
                    32'h0010_0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'hBEEF};
        vecs[2] = '{24'h7FFFFE, 1'b1, 1'b0, 1'b1, 16'h0000, 16'hA5C3, 0,
                    32'h007F_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 16'hA5C3};
        vecs[3] = '{24'hFFFFFE, 1'b0, 1'b0, 1'b0, 16'h1357, 16'hFFFF, 5,
                    32'h00FF_FFFE, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA5C3};
        vecs[4] = '{24'h000000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h8001, 7,
                    32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h8001};

        reset_n     = 1'b0;
        cpu_addr    = '0;
        cpu_data_in = '0;
        cpu_rw      = 1'b1;
        cpu_as_n    = 1'b1;
        cpu_uds_n   = 1'b1;
        cpu_lds_n   = 1'b1;
        master_read = '0;
        master_ack  = 1'b0;
        tick();
        tick();
        checkResetValues("reset");
        reset_n = 1'b1;
        repeat (3) tick();
        lastRead = 16'h0000;

        // Directed cycles, including the ack-in-last-REQ-cycle case (row 4).
        for (int i = 0; i < 5; i++) begin
            runCycle(vecs[i]);
            lastRead = vecs[i].expData;
        end

        // Randomized cycles checked against the transaction-level model.
        for (int i = 0; i < 16; i++) begin
            sel        = 2'($urandom_range(1, 3));
            v.byteAddr = 24'($urandom);
            v.rw       = 1'($urandom);
            v.udsN     = ~sel[1];
            v.ldsN     = ~sel[0];
            v.wdata    = 16'($urandom);
            v.rdata    = 16'($urandom);
            v.ackDelay = int'($urandom_range(0, 10));
            v.expAddr  = {8'h00, v.byteAddr} & 32'h00FF_FFFE;
            v.expUds   = sel[1];
            v.expLds   = sel[0];
            v.expBerr  = FEATURE && (v.ackDelay >= int'(TIMEOUT));
            v.expOe    = v.rw && !v.expBerr;
            v.expData  = (v.rw && !v.expBerr) ? v.rdata : lastRead;
            runCycle(v);
            lastRead = v.expData;
        end

`ifdef BRIDGE_BERR_TIMEOUT_EN
        // Unanswered access: BERR exactly after TIMEOUT REQ cycles.
        master_read = 16'h0000;
        applyStimulus(24'h200000, 1'b1, 1'b0, 1'b0, 16'h0000);
        waitStrobe(n);
        checkOutput("toAddr", master_addr, 32'h0020_0000);
        repeat (TIMEOUT - 1) tick();
        checkOutput("toBerrBefore", 32'(cpu_berr_n), 32'd1);
        tick();
        checkOutput("toBerr", 32'(cpu_berr_n), 32'd0);
        checkOutput("toDtack", 32'(cpu_dtack_n), 32'd1);
        checkOutput("toStrobes", 32'({master_uds, master_lds}), 32'd0);
        checkOutput("toOe", 32'(cpu_data_oe), 32'd0);
        tick();
        tick();
        checkOutput("toBerrHold", 32'(cpu_berr_n), 32'd0);
        releaseCpu();
        waitRelease(n);
        checkOutput("toRelease", 32'(n), 32'd3);
        tick();
        tick();
`else
        // Without the timeout feature a request waits for ack indefinitely.
        master_read = 16'h6E6E;
        applyStimulus(24'h200000, 1'b1, 1'b0, 1'b0, 16'h0000);
        waitStrobe(n);
        repeat (20) tick();
        checkOutput("noToBerr", 32'(cpu_berr_n), 32'd1);
        checkOutput("noToWait", 32'({master_uds, master_lds}), 32'd3);
        master_ack = 1'b1;
        tick();
        master_ack = 1'b0;
        checkOutput("noToDtack", 32'(cpu_dtack_n), 32'd0);
        checkOutput("noToData", 32'(cpu_data_out), 32'h6E6E);
        releaseCpu();
        waitRelease(n);
        tick();
        tick();
        lastRead = 16'h6E6E;
`endif

        // Back-to-back cycles with AS high for a single clock.
        master_read = 16'hC0DE;
        applyStimulus(24'h000000, 1'b1, 1'b0, 1'b0, 16'h0000);
        waitStrobe(n);
        checkOutput("b2bAddr1", master_addr, 32'h0000_0000);
        master_ack = 1'b1;
        tick();
        master_ack = 1'b0;
        checkOutput("b2bDtack1", 32'(cpu_dtack_n), 32'd0);
        releaseCpu();
        tick();
        applyStimulus(24'h100010, 1'b0, 1'b0, 1'b0, 16'h0F0F);
        rises = 0;
        overlap = 1'b0;
        prevStrb = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            curStrb = master_uds | master_lds;
            if (curStrb && !prevStrb) rises++;
            if (curStrb && !cpu_dtack_n) overlap = 1'b1;
            prevStrb = curStrb;
            if (curStrb) break;
        end
        checkOutput("b2bSecondReq", 32'(rises), 32'd1);
        checkOutput("b2bOverlap", 32'(overlap), 32'd0);
        checkOutput("b2bAddr2", master_addr, 32'h0010_0010);
        checkOutput("b2bRw2", 32'(master_rw), 32'd0);
        checkOutput("b2bWrite2", 32'(master_write), 32'h0F0F);
        master_ack = 1'b1;
        tick();
        master_ack = 1'b0;
        checkOutput("b2bData", 32'(cpu_data_out), 32'hC0DE);
        checkOutput("b2bOe2", 32'(cpu_data_oe), 32'd0);
        releaseCpu();
        waitRelease(n);
        tick();
        tick();
        lastRead = 16'hC0DE;

        // AS released while in REQ: request still held, ACK exits next cycle.
        master_read = 16'h5A5A;
        applyStimulus(24'h000802, 1'b1, 1'b0, 1'b0, 16'h0000);
        waitStrobe(n);
        releaseCpu();
        repeat (4) tick();
        checkOutput("earlyHold", 32'({master_uds, master_lds}), 32'd3);
        checkOutput("earlyDtackWait", 32'(cpu_dtack_n), 32'd1);
        master_ack = 1'b1;
        tick();
        master_ack = 1'b0;
        checkOutput("earlyDtack", 32'(cpu_dtack_n), 32'd0);
        checkOutput("earlyData", 32'(cpu_data_out), 32'h5A5A);
        tick();
        checkOutput("earlyExit", 32'(cpu_dtack_n), 32'd1);
        checkOutput("earlyOe", 32'(cpu_data_oe), 32'd0);
        tick();
        tick();

        // Reset pulsed while in REQ, with AS kept low afterwards.
        applyStimulus(24'h000100, 1'b1, 1'b0, 1'b0, 16'h0000);
        waitStrobe(n);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 checkResetValues("rstReq");
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        checkOutput("rstReqNoReq", 32'({master_uds, master_lds}), 32'd0);
        releaseCpu();
        repeat (3) tick();
        runCycle(vecs[0]);
        lastRead = vecs[0].expData;

        // Reset pulsed while in ACK, with AS kept low afterwards.
        master_read = 16'h1111;
        applyStimulus(24'h000200, 1'b1, 1'b0, 1'b0, 16'h0000);
        waitStrobe(n);
        master_ack = 1'b1;
        tick();
        master_ack = 1'b0;
        checkOutput("rstAckPre", 32'(cpu_dtack_n), 32'd0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 checkResetValues("rstAck");
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        checkOutput("rstAckNoReq", 32'({master_uds, master_lds}), 32'd0);
        checkOutput("rstAckNoDtack", 32'(cpu_dtack_n), 32'd1);
        releaseCpu();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/m68k_bus_bridge.md
Name: m68k_bus_bridge

Overview:
- Upstream neighbour of the address-decode mux: converts the asynchronous 68000 pin bus (AS/UDS/LDS/RW/DTACK/BERR) into the internal synchronous master bus.
- Internal master bus: active-high uds/lds strobes, ack handshake, 32-bit address, 16-bit data.
- Synchronises CPU strobes, holds a request until a slave acks, returns DTACK with latched read data.
- Terminates an unanswered cycle with BERR after a timeout.

Parameters:
- TIMEOUT_CYCLES, 255: clk cycles in REQ without master_ack before bus error. Legal range 2..65535.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- cpu_addr  in  23  CPU A[23:1].
- cpu_data_in  in  16  CPU data pins, write direction.
- cpu_data_out  out  16  data driven to CPU on reads.
- cpu_data_oe  out  1  1 = bridge drives the CPU data bus.
- cpu_as_n  in  1  address strobe, active low.
- cpu_uds_n  in  1  upper data strobe, active low.
- cpu_lds_n  in  1  lower data strobe, active low.
- cpu_rw  in  1  1 = read, 0 = write.
- cpu_dtack_n  out  1  data acknowledge, active low.
- cpu_berr_n  out  1  bus error, active low.
- master_addr  out  32  {8'h00, A[23:1], 1'b0}.
- master_write  out  16  write data to slaves.
- master_read  in  16  read data from the selected slave.
- master_uds  out  1  upper strobe, active high.
- master_lds  out  1  lower strobe, active high.
- master_rw  out  1  1 = read, 0 = write; new signal for slaves that need direction.
- master_ack  in  1  slave acknowledge, active high.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - cpu_dtack_n = 1, cpu_berr_n = 1, cpu_data_oe = 0, cpu_data_out = 0.
  - master_addr = 0, master_write = 0, master_uds = 0, master_lds = 0, master_rw = 1.
  - Timeout counter = 0; state = IDLE.
- Reset asserted mid-cycle forces these values immediately. After reset release the bridge stays in IDLE until cpu_as_n has been sampled high at least once, so a half-finished CPU cycle is never started.
- Synchronisers:
  - cpu_as_n, cpu_uds_n, cpu_lds_n pass through two flops each (as_s, uds_s, lds_s).
  - cpu_addr, cpu_rw and cpu_data_in are not synchronised. They are sampled only when the synchronised strobes qualify, at which point the 68000 guarantees they are stable.
- IDLE:
  - Transition condition: as_s == 0 and (uds_s == 0 or lds_s == 0).
  - On that condition, latch master_addr, master_rw = cpu_rw, master_write = cpu_data_in, master_uds = ~uds_s, master_lds = ~lds_s, clear the counter, go to REQ.
  - Strobes are visible on the 3rd rising edge after the CPU strobe falls.
- REQ:
  - Strobes held constant while in this state.
  - If master_ack == 1:
    - If master_rw == 1, cpu_data_out <= master_read.
    - Clear master_uds/lds; cpu_dtack_n <= 0; cpu_data_oe <= master_rw; go to ACK.
  - Otherwise the counter increments each cycle.
- ACK:
  - Hold dtack and oe until as_s == 1.
  - Then cpu_dtack_n <= 1, cpu_data_oe <= 0, go to IDLE.
  - cpu_data_out keeps its last value.
- BERR (see Optional Feature):
  - Strobes cleared, cpu_berr_n <= 0, cpu_data_oe = 0.
  - When as_s == 1: cpu_berr_n <= 1, go to IDLE.
- Simultaneous events:
  - master_ack in the same cycle the counter reaches TIMEOUT_CYCLES-1: ack wins.
  - master_ack seen outside REQ is ignored.
- Strobes released early: if the CPU deasserts AS while the bridge is in REQ (not legal 68000 behaviour), the bridge still waits for ack or timeout, then handles it as normal; ACK/BERR then exits on the next cycle.
- Exclusivity: only one request is outstanding at a time. master_uds/lds are never asserted outside REQ.

Optional Feature:
- Macro: BRIDGE_BERR_TIMEOUT_EN.
- Defined: counter and BERR state present. After TIMEOUT_CYCLES consecutive REQ cycles without ack, go to BERR on the next edge.
- Undefined: no counter, no BERR state; REQ waits for master_ack indefinitely; cpu_berr_n tied to 1.

Test Plan:
- Word read at 0x000400, slave acks 2 cycles after master strobes with 0xBEEF:
  - master_addr = 0x00000400, uds = lds = 1, master_rw = 1.
  - cpu_dtack_n = 0, cpu_data_out = 0xBEEF, oe = 1.
  - All released within 3 cycles of AS rising.
- Byte write at 0x100001 (LDS only), data 0x0055, ack after 1 cycle:
  - master_addr = 0x00100000, uds = 0, lds = 1, master_write = 0x0055, master_rw = 0.
  - cpu_data_oe stays 0.
- Access to 0x200000 with no ack, feature on, TIMEOUT_CYCLES = 8:
  - cpu_berr_n = 0 after exactly 8 REQ cycles; dtack never asserts; berr releases after AS high.
- Ack and timeout in the same cycle:
  - Ack arrives in the last REQ cycle: DTACK asserted, BERR stays 1.
- reset_n pulsed low in REQ and in ACK:
  - All outputs return to reset values asynchronously.
  - No new request until AS has been seen high.
- Back-to-back cycles (AS high for only 1 CPU clock) at 0x000000 then 0x100010:
  - Two distinct requests, correct addresses, no strobe overlap.
